// File: rtl/mod_pkg.sv
// Shared types for the modular-arithmetic datapath blocks.
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF1 = 2'd1,
        HALF2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_BITWIDTH = 8;

endpackage

// File: rtl/mod_quarterer_if.sv
// Operand/result valid-ready bundle for mod_quarterer.
interface mod_quarterer_if #(
    parameter int BITWIDTH = 8
);
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iQ;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH-1:0] oData;
    logic                oErr;

    modport slave (
        input  iValid, iData, iQ, iReady,
        output oReady, oValid, oData, oErr
    );

    modport master (
        output iValid, iData, iQ, iReady,
        input  oReady, oValid, oData, oErr
    );
endinterface

// File: rtl/mod_halver.sv
// Combinational modular halving: x/2 mod q for odd q and x < q.
module mod_halver #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] x_i,
    input  logic [BITWIDTH-1:0] q_i,
    output logic [BITWIDTH-1:0] half_o
);
    // (x + q) >> 1 rewritten as (x>>1) + (q>>1) + q[0] for odd x; identical to the
    // carry-extended sum truncated to BITWIDTH, without a dangling sum bit.
    assign half_o = (x_i >> 1)
                  + (x_i[0] ? ((q_i >> 1) + {{(BITWIDTH-1){1'b0}}, q_i[0]})
                            : {BITWIDTH{1'b0}});
endmodule

// File: rtl/mod_quarterer.sv
// Iterative modular quarterer: two registered halvings give x * 4^-1 mod q.
module mod_quarterer
    import mod_pkg::*;
#(
    parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iEn,
    input  logic        iClr,
    mod_quarterer_if.slave bus
);
    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] x_q, x_d;
    logic [BITWIDTH-1:0] q_q, q_d;
    logic                err_q, err_d;
    logic [BITWIDTH-1:0] half;

    mod_halver #(.BITWIDTH(BITWIDTH)) u_halver (
        .x_i    (x_q),
        .q_i    (q_q),
        .half_o (half)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            x_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a hold default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        q_d     = q_q;
        err_d   = err_q;
        if (iClr) begin
            state_d = IDLE;
            x_d     = '0;
            q_d     = '0;
            err_d   = 1'b0;
        end else if (iEn) begin
            unique case (state_q)
                IDLE: if (bus.iValid) begin
                    x_d     = bus.iData;
                    q_d     = bus.iQ;
                    err_d   = ~bus.iQ[0] | (bus.iData >= bus.iQ);
                    state_d = HALF1;
                end
                HALF1: begin
                    x_d     = half;
                    state_d = HALF2;
                end
                HALF2: begin
                    x_d     = half;
                    state_d = DONE;
                end
                DONE: if (bus.iReady) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs depend on registers only; no input reaches them combinationally.
    always_comb begin
        bus.oReady = 1'b0;
        bus.oValid = 1'b0;
        bus.oData  = '0;
        bus.oErr   = 1'b0;
        unique case (state_q)
            IDLE: bus.oReady = 1'b1;
            DONE: begin
                bus.oValid = 1'b1;
                bus.oErr   = err_q;
                bus.oData  = err_q ? '0 : x_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mod_quarterer.sv
// Self-checking bench for mod_quarterer against an arithmetic inverse-of-4 model.
module tb_mod_quarterer;
    logic clk;
    logic rst_n;
    logic iEn;
    logic iClr;
    int   checks;
    int   failures;

    mod_quarterer_if #(.BITWIDTH(8)) bus ();

    mod_quarterer #(.BITWIDTH(8)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .iEn   (iEn),
        .iClr  (iClr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the unique y < q with 4*y == x (mod q), found by search.
    function automatic int model_quarter(input int x, input int q);
        for (int y = 0; y < q; y++)
            if ((4 * y) % q == x) return y;
        return -1;
    endfunction

    task automatic send(input logic [7:0] x, input logic [7:0] q,
                        input int stall, input int hold, input string tag);
        int         lat;
        logic [7:0] exp_d;
        logic       exp_e;
        exp_e = (q[0] == 1'b0) || (x >= q);
        exp_d = exp_e ? 8'd0 : 8'(model_quarter(int'(x), int'(q)));

        lat = 0;
        while (!bus.oReady && lat < 10) begin @(negedge clk); lat++; end
        check({tag, " ready"}, 32'(bus.oReady), 32'd1);

        bus.iValid = 1'b1; bus.iData = x; bus.iQ = q;
        @(negedge clk);
        bus.iValid = 1'b0; bus.iData = 8'($urandom); bus.iQ = 8'($urandom);
        check({tag, " busy"}, 32'(bus.oReady), 32'd0);

        lat = 0;
        if (stall > 0) begin
            iEn = 1'b0;
            repeat (stall) begin @(negedge clk); lat++; end
            iEn = 1'b1;
        end
        while (!bus.oValid && lat < 20) begin
            if (bus.oData !== 8'd0) check({tag, " data_idle"}, 32'(bus.oData), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(2 + stall));
        check({tag, " data"}, 32'(bus.oData), 32'(exp_d));
        check({tag, " err"}, 32'(bus.oErr), 32'(exp_e));

        repeat (hold) begin
            bus.iValid = 1'b1; bus.iData = 8'($urandom); bus.iQ = 8'($urandom);
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(bus.oValid), 32'd1);
            check({tag, " hold_data"}, 32'(bus.oData), 32'(exp_d));
            check({tag, " hold_ready"}, 32'(bus.oReady), 32'd0);
        end
        bus.iValid = 1'b0;

        bus.iReady = 1'b1;
        @(negedge clk);
        bus.iReady = 1'b0;
        check({tag, " post_valid"}, 32'(bus.oValid), 32'd0);
        check({tag, " post_ready"}, 32'(bus.oReady), 32'd1);
        check({tag, " post_data"}, 32'(bus.oData), 32'd0);
    endtask

    // Launch an operation and kill it in HALF2 by reset or by clear (with iEn low).
    task automatic abort(input bit use_rst, input string tag);
        check({tag, " ready"}, 32'(bus.oReady), 32'd1);
        bus.iValid = 1'b1; bus.iData = 8'd17; bus.iQ = 8'd23;
        @(negedge clk);
        bus.iValid = 1'b0;
        @(negedge clk);
        if (use_rst) begin
            rst_n = 1'b0;
            #1;
        end else begin
            iClr = 1'b1;
            iEn  = 1'b0;
            @(negedge clk);
            iClr = 1'b0;
            iEn  = 1'b1;
        end
        check({tag, " valid"}, 32'(bus.oValid), 32'd0);
        check({tag, " data"}, 32'(bus.oData), 32'd0);
        check({tag, " rdy"}, 32'(bus.oReady), 32'd1);
        if (use_rst) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            check({tag, " no_result"}, 32'(bus.oValid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] rq, rx;
        int         mode;
        checks = 0; failures = 0;
        rst_n = 1'b0; iEn = 1'b1; iClr = 1'b0;
        bus.iValid = 1'b0; bus.iReady = 1'b0; bus.iData = '0; bus.iQ = '0;
        #1;
        check("reset valid", 32'(bus.oValid), 32'd0);
        check("reset err", 32'(bus.oErr), 32'd0);
        check("reset data", 32'(bus.oData), 32'd0);
        check("reset ready", 32'(bus.oReady), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'd17, 8'd23, 0, 0, "basic");
        foreach (rq[i]) ; // no-op keeps rq declared before the sweep
        for (int q = 23; q >= 15; q -= 2)
            send(8'((40) % q), 8'(q), 0, 0, $sformatf("round_q%0d", q));
        send(8'd254, 8'd255, 0, 0, "carry");
        send(8'd5, 8'd16, 0, 0, "even_q");
        send(8'd20, 8'd17, 0, 0, "x_ge_q");
        send(8'd17, 8'd23, 0, 5, "hold5");
        send(8'd17, 8'd23, 3, 0, "stall3");

        abort(1'b1, "abort_rst");
        send(8'd0, 8'd23, 0, 0, "after_rst");
        abort(1'b0, "abort_clr");
        send(8'd0, 8'd23, 0, 0, "after_clr");

        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 9));
            rq = 8'($urandom_range(3, 255)) | 8'd1;
            rx = 8'($urandom_range(0, int'(rq) - 1));
            if (mode == 0) rq = rq & 8'hFE;
            if (mode == 1) rx = 8'($urandom_range(int'(rq), 255));
            send(rx, rq,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
